// File: rtl/axi_ni_reorder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_ni_reorder_ctrl_pkg
// Brief    : Shared constants and width helper for the Slave NI per-TID
//            ordering controller.
// Revision : 1.0 - initial release
// ============================================================================
package axi_ni_reorder_ctrl_pkg;

    // One-hot channel encodings on reorder_req_op
    localparam logic [1:0] REORDER_OP_WR = 2'b01;
    localparam logic [1:0] REORDER_OP_RD = 2'b10;

    // Ceiling log2 that never returns 0, so a single-item field keeps 1 bit
    function automatic int log2c_1if1(input int x);
        int r;
        r = 0;
        while ((1 << r) < x) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_ni_reorder_table.sv
`default_nettype none
// ============================================================================
// Module   : axi_ni_reorder_table
// Brief    : One channel's per-TID tracking table {outstanding count, last
//            destination}: lookup, increment on qualify, decrement on retire.
// Revision : 1.0 - initial release
// ============================================================================
module axi_ni_reorder_table #(
    parameter int TIDS_M = 16,
    parameter int TW     = 4,
    parameter int DW     = 1,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] lookup_tid,
    output logic [CW-1:0] lookup_cnt,
    output logic [DW-1:0] lookup_dst,
    input  logic          inc,
    input  logic [TW-1:0] inc_tid,
    input  logic [DW-1:0] inc_dst,
    input  logic          dec,
    input  logic [TW-1:0] dec_tid,
    output logic          underflow
);

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic [DW-1:0] dst;
    } entry_t;

    entry_t              r_tbl [TIDS_M];
    logic [TIDS_M-1:0]   w_inc_hit;
    logic [TIDS_M-1:0]   w_dec_hit;

    // Entry lookup, per-entry hit decode and underflow detection
    always_comb begin
        lookup_cnt = '0;
        lookup_dst = '0;
        underflow  = 1'b0;
        w_inc_hit  = '0;
        w_dec_hit  = '0;
        for (int i = 0; i < TIDS_M; i++) begin
            if (lookup_tid == TW'(i)) begin
                lookup_cnt = r_tbl[i].cnt;
                lookup_dst = r_tbl[i].dst;
            end
            w_inc_hit[i] = inc && (inc_tid == TW'(i));
            // A retire against an empty entry is ignored and flagged
            if (dec && (dec_tid == TW'(i))) begin
                if (r_tbl[i].cnt == '0) underflow = 1'b1;
                else                    w_dec_hit[i] = 1'b1;
            end
        end
    end

    // Count/destination update; same-cycle qualify and retire cancel in cnt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TIDS_M; i++) r_tbl[i] <= '0;
        end else begin
            for (int i = 0; i < TIDS_M; i++) begin
                case ({w_inc_hit[i], w_dec_hit[i]})
                    2'b10: begin
                        r_tbl[i].cnt <= r_tbl[i].cnt + CW'(1);
                        r_tbl[i].dst <= inc_dst;
                    end
                    2'b11:   r_tbl[i].dst <= inc_dst;
                    2'b01:   r_tbl[i].cnt <= r_tbl[i].cnt - CW'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_ni_reorder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_ni_reorder_ctrl
// Brief    : Per-TID ordering controller for the Slave NI request path. Holds
//            back an AW/AR whose ID is still outstanding at another slave so
//            same-ID responses stay ordered across slaves.
// Config   : AXI_NI_REORDER_STRICT_EN - one outstanding transaction per
//            (channel, TID); otherwise same-destination pipelining up to
//            MAX_PENDING.
// Revision : 1.0 - initial release
// ============================================================================
module axi_ni_reorder_ctrl
    import axi_ni_reorder_ctrl_pkg::*;
#(
    parameter int TIDS_M      = 16,
    parameter int EXT_SLAVES  = 2,
    parameter int MAX_PENDING = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              reorder_req,
    input  logic [1:0]                        reorder_req_op,
    input  logic [log2c_1if1(TIDS_M)-1:0]     reorder_req_tid,
    input  logic [EXT_SLAVES-1:0]             reorder_req_dst_out,
    output logic [log2c_1if1(EXT_SLAVES)-1:0] reorder_req_dst_in,
    output logic                              reorder_qualify_now,
    input  logic                              wr_retire,
    input  logic [log2c_1if1(TIDS_M)-1:0]     wr_retire_tid,
    input  logic                              rd_retire,
    input  logic [log2c_1if1(TIDS_M)-1:0]     rd_retire_tid,
    output logic                              dec_err,
    output logic                              underflow_err
);

    localparam int TW = log2c_1if1(TIDS_M);
    localparam int DW = log2c_1if1(EXT_SLAVES);
`ifdef AXI_NI_REORDER_STRICT_EN
    localparam int CW = 1;
`else
    localparam int CW = $clog2(MAX_PENDING + 1);
`endif

    logic [DW-1:0] w_enc_dst;
    logic          w_dst_oh;
    logic          w_op_oh;
    logic          w_is_rd;
    logic [CW-1:0] w_wr_cnt, w_rd_cnt, w_sel_cnt;
    logic [DW-1:0] w_wr_dst, w_rd_dst, w_sel_dst;
    logic          w_entry_ok;
    logic          w_inc_wr, w_inc_rd;
    logic          w_wr_uflow, w_rd_uflow;
    logic          r_underflow;

    // One-hot to binary destination encode and one-hot checks
    always_comb begin
        w_enc_dst = '0;
        for (int i = 0; i < EXT_SLAVES; i++) begin
            if (reorder_req_dst_out[i]) w_enc_dst = w_enc_dst | DW'(i);
        end
        w_dst_oh = (reorder_req_dst_out != '0) &&
                   ((reorder_req_dst_out & (reorder_req_dst_out - EXT_SLAVES'(1))) == '0);
        w_op_oh  = (reorder_req_op == REORDER_OP_WR) || (reorder_req_op == REORDER_OP_RD);
    end

    assign reorder_req_dst_in = w_enc_dst;
    assign dec_err            = reorder_req && !(w_dst_oh && w_op_oh);

    // Qualify decision from registered state of the selected channel entry
    always_comb begin
        w_is_rd   = (reorder_req_op == REORDER_OP_RD);
        w_sel_cnt = w_is_rd ? w_rd_cnt : w_wr_cnt;
        w_sel_dst = w_is_rd ? w_rd_dst : w_wr_dst;
`ifdef AXI_NI_REORDER_STRICT_EN
        w_entry_ok = (w_sel_cnt == '0) && (w_sel_dst == w_sel_dst);
`else
        w_entry_ok = (w_sel_cnt == '0) ||
                     ((w_sel_dst == w_enc_dst) && (w_sel_cnt < CW'(MAX_PENDING)));
`endif
        reorder_qualify_now = !rst && reorder_req && !dec_err && w_entry_ok;
        w_inc_wr = reorder_qualify_now && !w_is_rd;
        w_inc_rd = reorder_qualify_now &&  w_is_rd;
    end

    axi_ni_reorder_table #(
        .TIDS_M (TIDS_M), .TW (TW), .DW (DW), .CW (CW)
    ) u_wr_table (
        .clk        (clk),
        .rst        (rst),
        .lookup_tid (reorder_req_tid),
        .lookup_cnt (w_wr_cnt),
        .lookup_dst (w_wr_dst),
        .inc        (w_inc_wr),
        .inc_tid    (reorder_req_tid),
        .inc_dst    (w_enc_dst),
        .dec        (wr_retire),
        .dec_tid    (wr_retire_tid),
        .underflow  (w_wr_uflow)
    );

    axi_ni_reorder_table #(
        .TIDS_M (TIDS_M), .TW (TW), .DW (DW), .CW (CW)
    ) u_rd_table (
        .clk        (clk),
        .rst        (rst),
        .lookup_tid (reorder_req_tid),
        .lookup_cnt (w_rd_cnt),
        .lookup_dst (w_rd_dst),
        .inc        (w_inc_rd),
        .inc_tid    (reorder_req_tid),
        .inc_dst    (w_enc_dst),
        .dec        (rd_retire),
        .dec_tid    (rd_retire_tid),
        .underflow  (w_rd_uflow)
    );

    // Sticky underflow flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           r_underflow <= 1'b0;
        else if (w_wr_uflow || w_rd_uflow) r_underflow <= 1'b1;
    end

    assign underflow_err = r_underflow;

endmodule
`default_nettype wire

// File: doc/axi_ni_reorder_ctrl.md
Name: axi_ni_reorder_ctrl

Overview:
Per-TID ordering controller for the Slave NI request path. It answers the request path's qualify handshake and blocks a new AW/AR from entering the NoC when the same AXI ID still has transactions outstanding at a different slave. This preserves AXI same-ID response ordering across slaves. It tracks outstanding-count and last destination per (channel, TID) and retires entries on responses from the NI response path.

Parameters:
TIDS_M, 16, number of AXI transaction IDs; TID width TW = log2c_1if1(TIDS_M)
EXT_SLAVES, 2, number of external slaves; binary dst width DW = log2c_1if1(EXT_SLAVES)
MAX_PENDING, 4, max outstanding transactions per (channel, TID); counter width CW = $clog2(MAX_PENDING+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
reorder_req  in  1  request path asks for qualification; held until qualified
reorder_req_op  in  2  one-hot channel: bit1 = read, bit0 = write
reorder_req_tid  in  TW  binary AXI ID of the request
reorder_req_dst_out  in  EXT_SLAVES  one-hot slave select from the address LUT
reorder_req_dst_in  out  DW  binary-encoded destination returned to the packetizer
reorder_qualify_now  out  1  request may proceed this cycle
wr_retire  in  1  write response (B) delivered to the master
wr_retire_tid  in  TW  ID of the retired write
rd_retire  in  1  last read beat (RLAST) delivered to the master
rd_retire_tid  in  TW  ID of the retired read
dec_err  out  1  combinational: reorder_req with zero-hot or multi-hot reorder_req_dst_out, or non-one-hot op
underflow_err  out  1  sticky: retire received with count = 0

Behaviour:
- Interface clocking: one clock, clk. Reset is asynchronous, active-high, on rst.
- State: two tables (write, read), TIDS_M entries each. Each entry holds cnt[CW-1:0] and dst[DW-1:0]. The two channels are fully independent.
- Reset: all cnt = 0, all dst = 0, underflow_err = 0. reorder_qualify_now is forced 0 while rst is high. Reset mid-transaction discards all tracking with no recovery.
- reorder_req_dst_in is a combinational one-hot-to-binary encode of reorder_req_dst_out, valid whenever the input is one-hot.
- Qualify rule (combinational, zero latency, uses registered state only):
  - qualify_now = reorder_req & !dec_err & (cnt == 0 | (dst == enc_dst & cnt < MAX_PENDING)).
  - The entry examined is the table selected by reorder_req_op, indexed by reorder_req_tid.
- Qualify is a one-cycle pulse per request, because the request path latches it internally. The controller must not re-qualify a held request:
  - On reorder_req & qualify_now: cnt += 1 and dst <= enc_dst.
  - A second qualification of the same request occurs only if the requester re-raises, which is legal and counts as a new transaction.
- Retire: on wr_retire (rd_retire), cnt of that TID in the write (read) table decrements by 1. dst is left unchanged.
- Simultaneous qualify and retire on the same entry: cnt unchanged, dst updated.
  - The qualify decision still uses the pre-retire cnt. Example: cnt = 1 at dst 0, new request to dst 1 with a same-cycle retire. The request is not qualified this cycle; it qualifies the next cycle.
- Simultaneous wr_retire and rd_retire: both applied, since the tables are independent.
- Saturation: cnt == MAX_PENDING blocks qualification even when dst matches. Increment beyond MAX_PENDING cannot occur.
- Underflow: retire with cnt == 0 leaves cnt at 0 and sets underflow_err (sticky until rst).
- dec_err: qualify_now is held 0 while dec_err is high. The request stalls; dec_err is a debug and assertion hook, and the bench asserts it never fires.

Optional Feature:
Macro AXI_NI_REORDER_STRICT_EN.
- Defined: at most one outstanding transaction per (channel, TID). Qualify requires cnt == 0, and MAX_PENDING is effectively 1. cnt may be implemented as 1 bit.
- Undefined: the same-destination pipelining rule above applies.

Decomposition:
- Package axi4_duth_noc_ni_pkg gains:
  - constants REORDER_OP_WR = 2'b01 and REORDER_OP_RD = 2'b10;
  - a typedef for the tracking entry {cnt, dst}, parameterised through localparam widths in the module.
- log2c_1if1 is reused from axi4_duth_noc_pkg.
- One natural sub-module, axi_ni_reorder_table: one channel's TIDS_M-entry table, with lookup, increment on qualify, and decrement on retire. It is instantiated twice, write and read.
- The one-hot encoder reuses the existing codebase encoder if present; otherwise it is inline.

Test Plan:
- Reset, then write req tid 3 dst 2'b01 -> qualify_now same cycle, dst_in = 0; write cnt[3] = 1.
- Write tid 3 cnt 1 at dst 0, new write tid 3 to dst 2'b10 -> qualify_now = 0; after wr_retire tid 3 -> qualify next cycle, dst_in = 1.
- Four reads tid 5 to dst 0 (MAX_PENDING = 4), fifth read tid 5 dst 0 -> fifth stalls until one rd_retire tid 5, then qualifies.
- Write tid 2 outstanding at dst 0, read tid 2 to dst 1 -> read qualifies immediately (independent tables).
- Same-cycle write qualify tid 7 (cnt 1 to 1, same dst) and wr_retire tid 7 -> cnt stays 1; rd_retire tid 9 with cnt 0 -> underflow_err = 1 and sticky.
- Request with dst_out = 2'b00 -> dec_err = 1, qualify_now = 0; with AXI_NI_REORDER_STRICT_EN, second write tid 1 to the same dst stalls until retire.
